parking_timer: RTL and testbench
================================

PARKING_TIMER -- requirements
Module: parking_timer

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of parking slots tracked.
REQ-002 SHALL have parameter SECS_PER_UNIT, default 3600, seconds per billing unit.
REQ-003 SHALL have parameter RATE, default 5, fee per billing unit.
REQ-004 SHALL have parameter UNIT_W, default 16, width of the per-slot unit counter.
REQ-005 SHALL have parameter FEE_W, default 24, fee output width.
REQ-006 SHALL have port clk_in  input  1  the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port tick_in  input  1  1 Hz square wave from the clock divider, sampled as data.
REQ-009 SHALL have port car_enter  input  1  one-cycle request: a car occupies slot_id.
REQ-010 SHALL have port car_exit  input  1  one-cycle request: a car leaves slot_id.
REQ-011 SHALL have port slot_id  input  $clog2(NUM_SLOTS)  target slot of enter/exit.
REQ-012 SHALL have port occupied  output  NUM_SLOTS  per-slot occupancy flags.
REQ-013 SHALL have port fee_valid  output  1  fee record available.
REQ-014 SHALL have port fee_ready  input  1  consumer accepts the fee record.
REQ-015 SHALL have port fee_out  output  FEE_W  charged fee.
REQ-016 SHALL have port fee_slot  output  $clog2(NUM_SLOTS)  slot the fee belongs to.
REQ-017 SHALL have port err  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-018 SHALL register tick_in once and generate a one-cycle sec_tick on each 0->1 transition; tick_in is never used as a clock.
REQ-019 Per slot, SHALL hold state FREE (occupied=0) or BUSY (occupied=1), plus sec counter (0..SECS_PER_UNIT-1) and unit counter (UNIT_W bits).
REQ-020 Enter on a FREE slot SHALL set BUSY, sec=0, units=1 (first unit is charged on entry) at the next edge.
REQ-021 On sec_tick every BUSY slot SHALL increment sec; at sec==SECS_PER_UNIT-1 sec wraps to 0 and units increments, saturating at all-ones.
REQ-022 Enter coinciding with sec_tick on the same slot SHALL take priority: that slot starts at sec=0, units=1.
REQ-023 Exit on a BUSY slot SHALL be accepted only if the output register is empty or drained that cycle (fee_valid=0 or fee_ready=1).
REQ-024 An accepted exit SHALL, at the next edge, set the slot FREE, load fee_out=units*RATE (truncated to FEE_W) and fee_slot=slot_id, and assert fee_valid (latency 1 cycle).
REQ-025 Units used for the fee SHALL be the pre-tick value when the exit coincides with sec_tick.
REQ-026 fee_valid SHALL stay high with fee_out/fee_slot stable until fee_valid&&fee_ready, then deassert unless a new exit loads the same edge.
REQ-027 err SHALL pulse for one cycle, with no state change, on: enter to BUSY slot; exit from FREE slot; exit blocked by REQ-023; enter and exit asserted together; slot_id>=NUM_SLOTS.

Reset
REQ-028 While rst=1 SHALL force all slots FREE, all sec/units 0, occupied=0, fee_valid=0, fee_out=0, fee_slot=0, err=0, tick history register=0.
REQ-029 Reset mid-occupancy SHALL discard all accumulated time with no fee produced; the first tick_in high after reset counts as a rising edge.

Structure
REQ-030 Package parking_pkg SHALL hold default NUM_SLOTS, SECS_PER_UNIT, RATE, UNIT_W, FEE_W and the slot-state enum (FREE, BUSY).
REQ-031 The tick edge detector SHALL be a sub-module rise_detect (clk_in, rst, d, pulse).
REQ-032 Fee multiply SHALL be a single registered stage; no further pipelining.

Verification (SECS_PER_UNIT=4, RATE=5, NUM_SLOTS=4)
REQ-033 Enter slot 2, 9 tick rising edges, exit -> next cycle fee_valid=1, fee_out=15 (units 3), fee_slot=2, occupied[2]=0.
REQ-034 Enter slot 0, exit with no tick -> fee_out=5; enter slot 0 twice -> second gives err pulse, occupied unchanged.
REQ-035 Hold fee_ready=0 after exit slot 1, then exit slot 3 -> err pulse, slot 3 stays BUSY, fee_slot stays 1; raise fee_ready and exit slot 3 same cycle -> fee_slot=3 next cycle.
REQ-036 Enter slot 1 on the same cycle as a tick edge, then 3 edges, exit on a 4th edge's cycle -> fee_out=5 (pre-tick units 1).
REQ-037 Assert rst while slots 0,3 BUSY -> next cycle occupied=0, fee_valid=0; exit slot 0 -> err pulse.
REQ-038 Force units to all-ones (UNIT_W=4), further wraps -> units stay 15, fee_out=75.

Source files
------------

// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parking_pkg
//  Description : Shared defaults, slot-state encoding and sizing helper for
//                the parking timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

  localparam int DEF_NUM_SLOTS     = 4;
  localparam int DEF_SECS_PER_UNIT = 3600;
  localparam int DEF_RATE          = 5;
  localparam int DEF_UNIT_W        = 16;
  localparam int DEF_FEE_W         = 24;

  // A slot is either empty or holding a car that is being billed.
  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } slot_state_e;

  // Bits needed to index n items, never less than one so ports stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parking_timer_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : Registers a slow data input once and emits a one-cycle pulse
//                while the input is high and its previous sample was low.
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // History register; cleared on reset so a high input right after reset
  // is seen as a fresh rising edge.
  always_ff @(posedge clk_in) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d && !d_q;

endmodule
`default_nettype wire

// File: rtl/parking_timer.sv
`default_nettype none
// ============================================================================
//  Module      : parking_timer
//  Description : Per-slot parking occupancy and time billing. Counts seconds
//                from a 1 Hz tick, accumulates billing units and emits a fee
//                record through a valid/ready output register on exit.
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_timer
  import parking_pkg::*;
#(
  parameter  int NUM_SLOTS     = DEF_NUM_SLOTS,
  parameter  int SECS_PER_UNIT = DEF_SECS_PER_UNIT,
  parameter  int RATE          = DEF_RATE,
  parameter  int UNIT_W        = DEF_UNIT_W,
  parameter  int FEE_W         = DEF_FEE_W,
  localparam int ID_W          = id_width(NUM_SLOTS)
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 tick_in,
  input  logic                 car_enter,
  input  logic                 car_exit,
  input  logic [ID_W-1:0]      slot_id,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic                 fee_valid,
  input  logic                 fee_ready,
  output logic [FEE_W-1:0]     fee_out,
  output logic [ID_W-1:0]      fee_slot,
  output logic                 err
);

  localparam int                SEC_W    = id_width(SECS_PER_UNIT);
  localparam logic [SEC_W-1:0]  SEC_LAST = SEC_W'(SECS_PER_UNIT - 1);
  localparam logic [UNIT_W-1:0] UNIT_MAX = '1;
  localparam logic [FEE_W-1:0]  RATE_F   = FEE_W'(RATE);

  logic sec_tick;

  rise_detect u_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (tick_in),
    .pulse  (sec_tick)
  );

  slot_state_e       state_q [NUM_SLOTS];
  slot_state_e       state_d [NUM_SLOTS];
  logic [SEC_W-1:0]  sec_q   [NUM_SLOTS];
  logic [SEC_W-1:0]  sec_d   [NUM_SLOTS];
  logic [UNIT_W-1:0] units_q [NUM_SLOTS];
  logic [UNIT_W-1:0] units_d [NUM_SLOTS];

  logic             fee_valid_d;
  logic [FEE_W-1:0] fee_out_d;
  logic [ID_W-1:0]  fee_slot_d;
  logic             err_d;

  logic id_ok;
  logic sel_busy;
  logic out_free;
  logic enter_ok;
  logic exit_ok;

  // Request qualification: anything asserted but not accepted is an error.
  always_comb begin
    id_ok    = ({1'b0, slot_id} < (ID_W + 1)'(NUM_SLOTS));
    sel_busy = id_ok && (state_q[slot_id] == BUSY);
    out_free = !fee_valid || fee_ready;
    enter_ok = car_enter && !car_exit && id_ok && !sel_busy;
    exit_ok  = car_exit && !car_enter && sel_busy && out_free;
    err_d    = (car_enter || car_exit) && !(enter_ok || exit_ok);
  end

  // Next-state for every slot and the fee record; enter/exit override the
  // tick update for the addressed slot, and the fee uses pre-tick units.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      sec_d[i]   = sec_q[i];
      units_d[i] = units_q[i];

      if (state_q[i] == BUSY && sec_tick) begin
        if (sec_q[i] == SEC_LAST) begin
          sec_d[i] = '0;
          if (units_q[i] != UNIT_MAX) units_d[i] = units_q[i] + 1'b1;
        end else begin
          sec_d[i] = sec_q[i] + 1'b1;
        end
      end

      if (enter_ok && slot_id == ID_W'(i)) begin
        state_d[i] = BUSY;
        sec_d[i]   = '0;
        units_d[i] = UNIT_W'(1);
      end

      if (exit_ok && slot_id == ID_W'(i)) begin
        state_d[i] = FREE;
        sec_d[i]   = '0;
        units_d[i] = '0;
      end
    end

    fee_valid_d = fee_valid;
    fee_out_d   = fee_out;
    fee_slot_d  = fee_slot;
    if (exit_ok) begin
      fee_valid_d = 1'b1;
      fee_out_d   = FEE_W'(units_q[slot_id]) * RATE_F;
      fee_slot_d  = slot_id;
    end else if (fee_valid && fee_ready) begin
      fee_valid_d = 1'b0;
    end
  end

  // State register for slots, fee record and error pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= FREE;
        sec_q[i]   <= '0;
        units_q[i] <= '0;
      end
      fee_valid <= 1'b0;
      fee_out   <= '0;
      fee_slot  <= '0;
      err       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        sec_q[i]   <= sec_d[i];
        units_q[i] <= units_d[i];
      end
      fee_valid <= fee_valid_d;
      fee_out   <= fee_out_d;
      fee_slot  <= fee_slot_d;
      err       <= err_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_occ
      assign occupied[g] = (state_q[g] == BUSY);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_parking_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_timer
//  Description : Self-checking bench for parking_timer with a behavioural
//                model (total ticks since entry -> units) plus directed cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_timer;

  localparam int NS   = 4;
  localparam int SPU  = 4;
  localparam int RT   = 5;
  localparam int UW   = 4;
  localparam int FW   = 24;
  localparam int UMAX = (1 << UW) - 1;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          tick_in = 1'b0;
  logic          car_enter = 1'b0;
  logic          car_exit = 1'b0;
  logic [1:0]    slot_id = '0;
  logic [NS-1:0] occupied;
  logic          fee_valid;
  logic          fee_ready = 1'b1;
  logic [FW-1:0] fee_out;
  logic [1:0]    fee_slot;
  logic          err;

  parking_timer #(
    .NUM_SLOTS     (NS),
    .SECS_PER_UNIT (SPU),
    .RATE          (RT),
    .UNIT_W        (UW),
    .FEE_W         (FW)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .tick_in   (tick_in),
    .car_enter (car_enter),
    .car_exit  (car_exit),
    .slot_id   (slot_id),
    .occupied  (occupied),
    .fee_valid (fee_valid),
    .fee_ready (fee_ready),
    .fee_out   (fee_out),
    .fee_slot  (fee_slot),
    .err       (err)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Behavioural model: occupancy, ticks elapsed since entry, fee register.
  bit m_occ   [NS];
  int m_ticks [NS];
  bit m_fv;
  int m_fout;
  int m_fslot;
  bit m_err;
  bit m_prev;

  function automatic int m_units(input int s);
    int u;
    u = 1 + m_ticks[s] / SPU;
    return (u > UMAX) ? UMAX : u;
  endfunction

  task automatic model_step();
    bit stick, acc_en, acc_ex, rej;
    int id;
    id = int'(slot_id);
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        m_occ[i] = 0;
        m_ticks[i] = 0;
      end
      m_fv = 0; m_fout = 0; m_fslot = 0; m_err = 0; m_prev = 0;
      return;
    end
    stick  = tick_in && !m_prev;
    m_prev = tick_in;
    acc_en = 0; acc_ex = 0; rej = 0;
    if (car_enter && car_exit)  rej = 1;
    else if (car_enter)         begin if (m_occ[id]) rej = 1; else acc_en = 1; end
    else if (car_exit)          begin
      if (!m_occ[id] || (m_fv && !fee_ready)) rej = 1;
      else acc_ex = 1;
    end
    if (acc_ex) begin
      m_fv = 1;
      m_fout = (m_units(id) * RT) % (1 << FW);
      m_fslot = id;
    end else if (m_fv && fee_ready) begin
      m_fv = 0;
    end
    for (int i = 0; i < NS; i++)
      if (m_occ[i] && stick) m_ticks[i]++;
    if (acc_en) begin m_occ[id] = 1; m_ticks[id] = 0; end
    if (acc_ex) begin m_occ[id] = 0; m_ticks[id] = 0; end
    m_err = rej;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NS-1:0] occ_exp;
    for (int i = 0; i < NS; i++) occ_exp[i] = m_occ[i];
    check("occupied",  32'(occupied),  32'(occ_exp));
    check("fee_valid", 32'(fee_valid), 32'(m_fv));
    check("fee_out",   32'(fee_out),   32'(m_fout));
    check("fee_slot",  32'(fee_slot),  32'(m_fslot));
    check("err",       32'(err),       32'(m_err));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge,
  // then one-cycle requests are released.
  task automatic cyc();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    compare_all();
    car_enter = 1'b0;
    car_exit  = 1'b0;
  endtask

  task automatic tick_edges(input int n);
    for (int k = 0; k < n; k++) begin
      tick_in = 1'b1; cyc();
      tick_in = 1'b0; cyc();
    end
  endtask

  task automatic req(input bit en, input bit ex, input int id);
    car_enter = en;
    car_exit  = ex;
    slot_id   = 2'(id);
  endtask

  initial begin
    // Reset state
    rst = 1'b1; cyc(); cyc();
    check("rst_occupied", 32'(occupied), 32'd0);
    check("rst_fee_valid", 32'(fee_valid), 32'd0);
    check("rst_fee_out", 32'(fee_out), 32'd0);
    rst = 1'b0; cyc();

    // Three units after nine ticks
    req(1, 0, 2); cyc();
    tick_edges(9);
    req(0, 1, 2); cyc();
    check("lit_fee9_valid", 32'(fee_valid), 32'd1);
    check("lit_fee9_out", 32'(fee_out), 32'd15);
    check("lit_fee9_slot", 32'(fee_slot), 32'd2);
    check("lit_fee9_occ2", 32'(occupied[2]), 32'd0);
    check("model_fee9", 32'(m_fout), 32'd15);
    cyc();

    // Immediate exit charges the first unit; double enter is rejected
    req(1, 0, 0); cyc();
    req(0, 1, 0); cyc();
    check("lit_fee0_out", 32'(fee_out), 32'd5);
    req(1, 0, 0); cyc();
    req(1, 0, 0); cyc();
    check("lit_dbl_enter_err", 32'(err), 32'd1);
    check("lit_dbl_enter_occ", 32'(occupied), 32'b0001);
    req(0, 1, 0); cyc();
    req(0, 1, 0); cyc();
    check("lit_exit_free_err", 32'(err), 32'd1);

    // Output register back-pressure
    fee_ready = 1'b0;
    cyc();
    req(1, 0, 1); cyc();
    req(1, 0, 3); cyc();
    req(0, 1, 1); cyc();
    check("lit_bp_slot1", 32'(fee_slot), 32'd1);
    req(0, 1, 3); cyc();
    check("lit_bp_err", 32'(err), 32'd1);
    check("lit_bp_occ3", 32'(occupied[3]), 32'd1);
    check("lit_bp_keep_slot", 32'(fee_slot), 32'd1);
    fee_ready = 1'b1;
    req(0, 1, 3); cyc();
    check("lit_bp_slot3", 32'(fee_slot), 32'd3);
    cyc();

    // Enter on a tick edge; exit on the fourth following edge
    tick_in = 1'b1; req(1, 0, 1); cyc();
    tick_in = 1'b0; cyc();
    tick_edges(3);
    tick_in = 1'b1; req(0, 1, 1); cyc();
    check("lit_pretick_fee", 32'(fee_out), 32'd5);
    tick_in = 1'b0; cyc();

    // Reset while occupied
    req(1, 0, 0); cyc();
    req(1, 0, 3); cyc();
    tick_edges(5);
    rst = 1'b1; cyc();
    check("lit_rst_occ", 32'(occupied), 32'd0);
    check("lit_rst_fv", 32'(fee_valid), 32'd0);
    rst = 1'b0;
    req(0, 1, 0); cyc();
    check("lit_rst_exit_err", 32'(err), 32'd1);

    // Unit counter saturation
    req(1, 0, 2); cyc();
    tick_edges(70);
    req(0, 1, 2); cyc();
    check("lit_sat_fee", 32'(fee_out), 32'd75);
    check("model_sat_fee", 32'(m_fout), 32'd75);
    cyc();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 9);
      car_enter = (r <= 2) || (r == 6);
      car_exit  = (r >= 3 && r <= 6);
      slot_id   = 2'($urandom_range(0, NS - 1));
      fee_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
